seu_record_arbiter: RTL

- Shares one 32-bit readout stream among NCH prbs7 checker channels in the SEU test firmware.
- Each cycle a channel's 256-bit record has its errorFlag bit (bit 255) set, that record is captured into a one-deep per-channel shadow register.
- Pending channels are granted round-robin. The granted record is serialized as 8 words over a valid/ready handshake toward the uplink FIFO.
- Records arriving while a channel's shadow is occupied are counted as drops.

---
 rtl/seu_record_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/seu_record_arbiter.sv
// rtl/seu_record_arbiter.sv - round-robin arbiter serializing flagged prbs7 checker records onto one 32-bit stream
//
// Captures each channel's 256-bit record into a one-deep shadow when its errorFlag
// (bit 255) is set, grants pending channels round-robin and streams the granted
// record as 32-bit words (MSW first) over a valid/ready handshake.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rec_in              NCH concatenated 256-bit records, channel c at [c*256 +: 256]
//   ch_enable           per-channel capture enable
//   clear               single-cycle pulse zeroing all drop counters
//   dout/dout_valid/dout_ready/dout_sop/dout_eop   outgoing word stream
//   drop_count          per-channel saturating drop counters, channel c at [c*DROP_W +: DROP_W]
//   busy                sending, or any channel pending
//
// Optional: define SEU_ARB_HEADER_EN to prefix each packet with a header word
//   {8'hA5, channel[3:0], drop_count[15:0], 4'h0} (9-word packets).
module seu_record_arbiter #(
  parameter int NCH    = 7,
  parameter int DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH*256-1:0]      rec_in,
  input  logic [NCH-1:0]          ch_enable,
  input  logic                    clear,
  output logic [31:0]             dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_sop,
  output logic                    dout_eop,
  output logic [NCH*DROP_W-1:0]   drop_count,
  output logic                    busy
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef SEU_ARB_HEADER_EN
  localparam int NWORDS = 9;
`else
  localparam int NWORDS = 8;
`endif
  localparam int OBUF_W = NWORDS * 32;
  localparam logic [3:0] LAST_IDX = 4'(NWORDS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [OBUF_W-1:0] obuf_q, obuf_d;
  logic [NCH-1:0]    pend_q, pend_d;
  logic [255:0]      shadow_q [NCH];
  logic [255:0]      shadow_d [NCH];
  logic [DROP_W-1:0] drop_q [NCH];
  logic [DROP_W-1:0] drop_d [NCH];

  logic [NCH-1:0]    rel;
  logic [CH_W-1:0]   grant;
  logic              found;
  logic [CH_W:0]     cand;
  logic              hit;

  // Round-robin search: first pending channel strictly after rr, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = {1'b0, rr_q} + (CH_W+1)'(i);
      if (cand >= (CH_W+1)'(NCH)) cand = cand - (CH_W+1)'(NCH);
      if (!found && pend_q[cand[CH_W-1:0]]) begin
        found = 1'b1;
        grant = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    obuf_d   = obuf_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    drop_d   = drop_q;
    rel      = '0;
    hit      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          rel[grant] = 1'b1;
`ifdef SEU_ARB_HEADER_EN
          obuf_d = {8'hA5, 4'(grant), 16'(drop_q[grant]), 4'h0, shadow_q[grant]};
`else
          obuf_d = shadow_q[grant];
`endif
          rr_d    = grant;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      default: begin
        if (dout_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
    endcase

    // A release frees the shadow in the same edge, so a simultaneous hit refills it.
    for (int c = 0; c < NCH; c++) begin
      hit = ch_enable[c] & rec_in[c*256 + 255];
      if (hit && (!pend_q[c] || rel[c])) begin
        shadow_d[c] = rec_in[c*256 +: 256];
        pend_d[c]   = 1'b1;
      end else if (rel[c]) begin
        pend_d[c] = 1'b0;
      end
      if (clear) begin
        drop_d[c] = '0;
      end else if (hit && pend_q[c] && !rel[c] && (drop_q[c] != {DROP_W{1'b1}})) begin
        drop_d[c] = drop_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rr_q    <= CH_W'(NCH - 1);
      obuf_q  <= '0;
      pend_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        shadow_q[c] <= '0;
        drop_q[c]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      obuf_q   <= obuf_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      drop_q   <= drop_d;
    end
  end

  // Word 0 is the most significant 32 bits of the output buffer.
  always_comb begin
    dout = '0;
    if (state_q == S_SEND) begin
      for (int w = 0; w < NWORDS; w++) begin
        if (idx_q == 4'(w)) dout = obuf_q[(NWORDS-1-w)*32 +: 32];
      end
    end
  end

  always_comb begin
    drop_count = '0;
    for (int c = 0; c < NCH; c++) drop_count[c*DROP_W +: DROP_W] = drop_q[c];
  end

  assign dout_valid = (state_q == S_SEND);
  assign dout_sop   = (state_q == S_SEND) && (idx_q == 4'd0);
  assign dout_eop   = (state_q == S_SEND) && (idx_q == LAST_IDX);
  assign busy       = (state_q == S_SEND) || (|pend_q);

endmodule
